// File: rtl/cpu_pkg.sv
// Shared constants and types for the instruction-entry front end and the CPU core.
package cpu_pkg;

    localparam int OPCODE_W           = 4;
    localparam int REG_ID_W           = 4;
    localparam int DEFAULT_MAX_REG_ID = 7;

    typedef enum logic [1:0] {
        ST_OP    = 2'd0,
        ST_R1    = 2'd1,
        ST_R2    = 2'd2,
        ST_ISSUE = 2'd3
    } entry_state_t;

    function automatic logic reg_id_legal(input logic [REG_ID_W-1:0] id, input int max_id);
        return int'(id) <= max_id;
    endfunction

endpackage

// File: rtl/instr_entry_if.sv
// Instruction handshake between the entry unit (master) and the CPU datapath (slave).
interface instr_entry_if;
    import cpu_pkg::*;

    logic [OPCODE_W-1:0] opCode;
    logic [REG_ID_W-1:0] regID1;
    logic [REG_ID_W-1:0] regID2;
    logic                instrValid;
    logic                instrReady;

    modport master (
        output opCode, regID1, regID2, instrValid,
        input  instrReady
    );

    modport slave (
        input  opCode, regID1, regID2, instrValid,
        output instrReady
    );

endinterface

// File: rtl/button_debounce.sv
// Synchronises and debounces an active-low pushbutton, emitting one pulse per press.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic resetButton,
    input  logic rawN,
    output logic pressPulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync_a;
    logic             sync_b;
    logic             deb_level;
    logic             deb_d1;
    logic             deb_d2;
    logic [CNT_W-1:0] count;

    // Two delay stages after the debounced level put the press pulse at edge DEBOUNCE_CYCLES+3
    always_ff @(posedge clock or negedge resetButton) begin
        if (!resetButton) begin
            sync_a     <= 1'b1;
            sync_b     <= 1'b1;
            deb_level  <= 1'b1;
            deb_d1     <= 1'b1;
            deb_d2     <= 1'b1;
            count      <= '0;
            pressPulse <= 1'b0;
        end else begin
            sync_a <= rawN;
            sync_b <= sync_a;
            if (sync_b == deb_level) begin
                count <= '0;
            end else if (count == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                deb_level <= sync_b;
                count     <= '0;
            end else begin
                count <= count + 1'b1;
            end
            deb_d1     <= deb_level;
            deb_d2     <= deb_d1;
            pressPulse <= deb_d2 & ~deb_d1;
        end
    end

endmodule

// File: rtl/instr_entry.sv
// Builds opCode/regID1/regID2 from switch entries and hands the instruction to the CPU.
module instr_entry
    import cpu_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int MAX_REG_ID      = DEFAULT_MAX_REG_ID
) (
    input  logic          clock,
    input  logic          resetButton,
    input  logic          setButton,
    input  logic [3:0]    inputs,
    instr_entry_if.master bus,
    output logic [1:0]    Q,
    output logic          badID
);

    entry_state_t        state;
    entry_state_t        next_state;
    logic [OPCODE_W-1:0] op_next;
    logic [REG_ID_W-1:0] reg1_next;
    logic [REG_ID_W-1:0] reg2_next;
    logic                valid_next;
    logic                bad_next;
    logic                press;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock      (clock),
        .resetButton(resetButton),
        .rawN       (setButton),
        .pressPulse (press)
    );

    always_ff @(posedge clock or negedge resetButton) begin
        if (!resetButton) begin
            state          <= ST_OP;
            bus.opCode     <= '0;
            bus.regID1     <= '0;
            bus.regID2     <= '0;
            bus.instrValid <= 1'b0;
            badID          <= 1'b0;
        end else begin
            state          <= next_state;
            bus.opCode     <= op_next;
            bus.regID1     <= reg1_next;
            bus.regID2     <= reg2_next;
            bus.instrValid <= valid_next;
            badID          <= bad_next;
        end
    end

    // Presses while in ISSUE fall through untouched, so they are dropped rather than queued
    always_comb begin
        next_state = state;
        op_next    = bus.opCode;
        reg1_next  = bus.regID1;
        reg2_next  = bus.regID2;
        valid_next = bus.instrValid;
        bad_next   = 1'b0;
        case (state)
            ST_OP: begin
                if (press) begin
                    op_next    = inputs;
                    next_state = ST_R1;
                end
            end
            ST_R1: begin
                if (press) begin
                    if (reg_id_legal(inputs, MAX_REG_ID)) begin
                        reg1_next  = inputs;
                        next_state = ST_R2;
                    end else begin
                        bad_next = 1'b1;
                    end
                end
            end
            ST_R2: begin
                if (press) begin
                    if (reg_id_legal(inputs, MAX_REG_ID)) begin
                        reg2_next  = inputs;
                        valid_next = 1'b1;
                        next_state = ST_ISSUE;
                    end else begin
                        bad_next = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (bus.instrReady) begin
                    valid_next = 1'b0;
                    next_state = ST_OP;
                end
            end
            default: next_state = ST_OP;
        endcase
    end

    assign Q = state;

endmodule

// File: tb/tb_instr_entry.sv
// Scoreboard bench for instr_entry: directed presses, handshake monitor and badID monitor.
module tb_instr_entry;
    import cpu_pkg::*;

    localparam int DEB = 4;

    typedef struct {
        logic [3:0] op;
        logic [3:0] r1;
        logic [3:0] r2;
    } instr_t;

    logic       clock       = 1'b0;
    logic       resetButton = 1'b0;
    logic       setButton   = 1'b1;
    logic [3:0] inputs      = 4'h0;
    logic [1:0] Q;
    logic       badID;

    instr_t     expQ[$];
    logic [1:0] badExpQ[$];
    int         checks     = 0;
    int         errors     = 0;
    int         pulseCount = 0;
    int         badCount   = 0;
    logic       prevBad    = 1'b0;

    instr_entry_if bus ();

    instr_entry #(
        .DEBOUNCE_CYCLES(DEB),
        .MAX_REG_ID     (7)
    ) dut (
        .clock      (clock),
        .resetButton(resetButton),
        .setButton  (setButton),
        .inputs     (inputs),
        .bus        (bus),
        .Q          (Q),
        .badID      (badID)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Press with the given switch value, hold, then release and let the debouncer settle
    task automatic applyStimulus(input logic [3:0] value, input int holdCycles);
        inputs    = value;
        setButton = 1'b0;
        repeat (holdCycles) @(posedge clock);
        #1 setButton = 1'b1;
        repeat (10) @(posedge clock);
        #1;
    endtask

    task automatic handshake();
        bus.instrReady = 1'b1;
        @(posedge clock);
        #1 bus.instrReady = 1'b0;
    endtask

    task automatic checkInstr(input string tag, input logic [1:0] q, input logic valid,
                              input logic [3:0] op, input logic [3:0] r1, input logic [3:0] r2);
        checkOutput({tag, "_Q"}, 8'(Q), 8'(q));
        checkOutput({tag, "_valid"}, 8'(bus.instrValid), 8'(valid));
        checkOutput({tag, "_opCode"}, 8'(bus.opCode), 8'(op));
        checkOutput({tag, "_regID1"}, 8'(bus.regID1), 8'(r1));
        checkOutput({tag, "_regID2"}, 8'(bus.regID2), 8'(r2));
    endtask

    // Monitor: pops the scoreboard on every accepted handshake and on every badID pulse
    always @(negedge clock) begin
        instr_t exp;
        if (dut.u_debounce.pressPulse) pulseCount++;
        if (bus.instrValid && bus.instrReady) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL hs_unexpected: got op=%0h r1=%0h r2=%0h, expected no instruction",
                         bus.opCode, bus.regID1, bus.regID2);
            end else begin
                exp = expQ.pop_front();
                checkOutput("hs_opCode", 8'(bus.opCode), 8'(exp.op));
                checkOutput("hs_regID1", 8'(bus.regID1), 8'(exp.r1));
                checkOutput("hs_regID2", 8'(bus.regID2), 8'(exp.r2));
            end
        end
        if (badID) begin
            badCount++;
            checkOutput("badID_width", 8'(prevBad), 8'(0));
            if (badExpQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL badID_unexpected: got pulse in Q=%0d, expected none", Q);
            end else begin
                checkOutput("badID_state", 8'(Q), 8'(badExpQ.pop_front()));
            end
        end
        prevBad = badID;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int p0;
        bus.instrReady = 1'b0;
        repeat (3) @(posedge clock);
        #1 resetButton = 1'b1;
        checkInstr("rst", 2'd0, 1'b0, 4'h0, 4'h0, 4'h0);
        checkOutput("rst_badID", 8'(badID), 8'(0));
        repeat (50) @(posedge clock);
        #1;
        checkInstr("idle", 2'd0, 1'b0, 4'h0, 4'h0, 4'h0);
        checkOutput("idle_badCount", 8'(badCount), 8'(0));

        // Latency: edge 0 is the first edge that samples the button low
        inputs    = 4'h1;
        setButton = 1'b0;
        repeat (7) @(posedge clock);
        #1 checkOutput("lat_pulse_e6", 8'(dut.u_debounce.pressPulse), 8'(0));
        @(posedge clock);
        #1 checkOutput("lat_pulse_e7", 8'(dut.u_debounce.pressPulse), 8'(1));
        checkOutput("lat_Q_e7", 8'(Q), 8'(0));
        @(posedge clock);
        #1 checkOutput("lat_Q_e8", 8'(Q), 8'(1));
        checkOutput("lat_op_e8", 8'(bus.opCode), 8'(1));
        checkOutput("lat_pulse_e8", 8'(dut.u_debounce.pressPulse), 8'(0));
        repeat (100) @(posedge clock);
        #1 checkOutput("hold_Q", 8'(Q), 8'(1));
        checkOutput("hold_pulses", 8'(pulseCount), 8'(1));
        setButton = 1'b1;
        repeat (10) @(posedge clock);
        #1 checkOutput("release_pulses", 8'(pulseCount), 8'(1));

        // Rejected regID1, then legal entries through to ISSUE
        badExpQ.push_back(2'd1);
        applyStimulus(4'h9, 10);
        checkInstr("bad_r1", 2'd1, 1'b0, 4'h1, 4'h0, 4'h0);
        checkOutput("bad_r1_count", 8'(badCount), 8'(1));
        applyStimulus(4'h3, 10);
        checkInstr("r1_ok", 2'd2, 1'b0, 4'h1, 4'h3, 4'h0);
        expQ.push_back('{op: 4'h1, r1: 4'h3, r2: 4'h5});
        applyStimulus(4'h5, 10);
        checkInstr("issue_a", 2'd3, 1'b1, 4'h1, 4'h3, 4'h5);
        repeat (20) @(posedge clock);
        #1 checkInstr("stable_a", 2'd3, 1'b1, 4'h1, 4'h3, 4'h5);
        applyStimulus(4'h2, 10);
        applyStimulus(4'h9, 10);
        checkInstr("ignore_a", 2'd3, 1'b1, 4'h1, 4'h3, 4'h5);
        checkOutput("ignore_badCount", 8'(badCount), 8'(1));
        handshake();
        checkInstr("done_a", 2'd0, 1'b0, 4'h1, 4'h3, 4'h5);

        expQ.push_back('{op: 4'h0, r1: 4'h2, r2: 4'h5});
        applyStimulus(4'h0, 10);
        applyStimulus(4'h2, 10);
        applyStimulus(4'h5, 10);
        checkInstr("issue_b", 2'd3, 1'b1, 4'h0, 4'h2, 4'h5);
        handshake();
        checkInstr("done_b", 2'd0, 1'b0, 4'h0, 4'h2, 4'h5);

        // Boundary IDs: 7 accepted, 8 rejected in both register slots
        applyStimulus(4'hF, 10);
        badExpQ.push_back(2'd1);
        applyStimulus(4'h8, 10);
        checkInstr("bnd_r1_bad", 2'd1, 1'b0, 4'hF, 4'h2, 4'h5);
        applyStimulus(4'h7, 10);
        badExpQ.push_back(2'd2);
        applyStimulus(4'h8, 10);
        checkInstr("bnd_r2_bad", 2'd2, 1'b0, 4'hF, 4'h7, 4'h5);
        expQ.push_back('{op: 4'hF, r1: 4'h7, r2: 4'h0});
        applyStimulus(4'h0, 10);
        checkInstr("issue_c", 2'd3, 1'b1, 4'hF, 4'h7, 4'h0);
        handshake();
        checkInstr("done_c", 2'd0, 1'b0, 4'hF, 4'h7, 4'h0);

        // Glitches shorter than the debounce window
        p0 = pulseCount;
        for (int n = 1; n <= 3; n++) begin
            inputs    = 4'h4;
            setButton = 1'b0;
            repeat (n) @(posedge clock);
            #1 setButton = 1'b1;
            repeat (10) @(posedge clock);
            #1;
        end
        checkOutput("glitch_pulses", 8'(pulseCount - p0), 8'(0));
        checkInstr("glitch", 2'd0, 1'b0, 4'hF, 4'h7, 4'h0);

        // Asynchronous reset in the middle of an entry
        applyStimulus(4'h6, 10);
        applyStimulus(4'h4, 10);
        checkInstr("pre_rst", 2'd2, 1'b0, 4'h6, 4'h4, 4'h0);
        @(negedge clock);
        #2 resetButton = 1'b0;
        #1 checkInstr("async_rst", 2'd0, 1'b0, 4'h0, 4'h0, 4'h0);
        @(posedge clock);
        #1 resetButton = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        applyStimulus(4'hA, 10);
        checkInstr("post_rst", 2'd1, 1'b0, 4'hA, 4'h0, 4'h0);

        checkOutput("sb_instr_empty", 8'(expQ.size()), 8'(0));
        checkOutput("sb_bad_empty", 8'(badExpQ.size()), 8'(0));
        checkOutput("total_badCount", 8'(badCount), 8'(3));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_entry.md
Name: instr_entry

Overview:
- Front-end input unit. Turns the board's raw switch nibble and an active-low set pushbutton into a complete, validated instruction: opCode, regID1, regID2.
- Presents the instruction to the CPU datapath with a valid/ready handshake.
- Owns button synchronisation, debounce and the entry state sequence. The CPU core only consumes finished instructions and drives the 7-seg display.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable synchronised cycles needed before the debounced button level changes (board build uses 500000 at 50 MHz).
- MAX_REG_ID, 7, highest legal register ID; larger IDs are rejected.

Ports:
- clock  in  1  system clock; all flops on posedge.
- resetButton  in  1  reset, asynchronous, active-low.
- setButton  in  1  raw pushbutton, active-low, asynchronous to clock.
- inputs  in  4  raw switch nibble, quasi-static.
- opCode  out  4  captured operation code.
- regID1  out  4  captured first register ID.
- regID2  out  4  captured second register ID.
- instrValid  out  1  instruction complete and stable.
- instrReady  in  1  CPU accepts the instruction.
- Q  out  2  entry state, for the display mux: 0 = OP, 1 = R1, 2 = R2, 3 = ISSUE.
- badID  out  1  one-cycle pulse when a register ID is rejected.

Behaviour:
- Reset, asynchronous on resetButton low:
  - Q = OP.
  - opCode, regID1, regID2 = 0.
  - instrValid = 0, badID = 0.
  - Synchroniser flops = 1, debounced level = 1 (released), debounce counter = 0, press pulse = 0.
  - Reset mid-entry or mid-ISSUE discards any partial or pending instruction.
- Synchroniser: two flops on setButton; the second flop output is the sync level.
- Debounce:
  - If sync level equals the debounced level, the counter clears.
  - Otherwise the counter increments each cycle.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level takes the sync level on the next edge and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles produces no change.
- Press pulse: registered, high for exactly one cycle following a debounced 1->0 transition. Release (0->1) produces no pulse.
- Latency: the first edge sampling setButton low is edge 0. The press pulse is high after edge DEBOUNCE_CYCLES+3, and capture occurs at the next edge.
- FSM, acting on the press pulse:
  - OP: opCode <= inputs, go to R1. Any opCode is legal.
  - R1: if inputs <= MAX_REG_ID, regID1 <= inputs and go to R2. Otherwise hold the state, leave regID1 unchanged, and pulse badID for one cycle.
  - R2: same rule as R1 for regID2. On an accepted capture, go to ISSUE and set instrValid = 1 on the same edge.
  - ISSUE:
    - opCode, regID1, regID2 and instrValid are held stable.
    - On an edge with instrReady = 1: instrValid <= 0, Q <= OP.
    - Presses in ISSUE are ignored, not queued. A press coinciding with instrReady is dropped.
- instrReady is ignored outside ISSUE.
- Registered outputs keep their last captured values after the handshake until overwritten by the next capture.
- Continuous button hold yields exactly one press pulse; the next pulse requires release plus a new press.

Decomposition:
- Shared package (cpu_pkg) holds:
  - state encoding constants ST_OP = 0, ST_R1 = 1, ST_R2 = 2, ST_ISSUE = 3;
  - REG_ID_W = 4 and OPCODE_W = 4;
  - MAX_REG_ID default 7.
- One sub-module, button_debounce, containing the synchroniser, counter, debounced level and press pulse.
  - Parameter DEBOUNCE_CYCLES; ports clock, resetButton, rawN, pressPulse.
  - Reused later for displayButton.

Test Plan:
- Reset release with setButton high, idle 50 cycles -> Q = 0, instrValid = 0, all IDs 0, badID never high.
- DEBOUNCE_CYCLES=4, inputs = 4'b0001, setButton low from edge 0 -> press pulse after edge 7; opCode = 1 and Q = 1 after edge 8. Holding the button 100 cycles yields no second capture.
- Full entry with opCode = 0, regID1 = 2, regID2 = 5, instrReady held 0 -> Q = 3 and instrValid = 1, stable for 20 cycles. Extra presses leave all values unchanged. Raising instrReady for one cycle -> instrValid = 0 and Q = 0 after that edge.
- In R1, inputs = 4'b1001 plus press -> badID high exactly one cycle, Q stays 1, regID1 unchanged. Then inputs = 3 plus press -> regID1 = 3, Q = 2.
- setButton glitches of 1, 2 and 3 cycles low (DEBOUNCE_CYCLES=4) -> no press pulse, no state change.
- resetButton low asynchronously (between clock edges) while Q = 2 with regID1 = 4 -> Q = 0, all outputs 0 immediately without a clock edge. After release, the next entry starts from OP.
